// File: rtl/dual_mac_pkg.sv
// Shared types and helpers for the packed dual-lane MAC.
// Optional macro ACC_SAT_EN (see packed_dual_mac) uses sat_add from here.
package dual_mac_pkg;

    localparam int unsigned MAX_PW    = 32;
    localparam int unsigned MAX_P_W   = 2 * MAX_PW + 1;
    localparam int unsigned MAX_ACC_W = 64;
    localparam int unsigned MAX_SUM_W = MAX_ACC_W + 1;

    typedef logic signed [MAX_PW-1:0] lane_prod_t;

    function automatic int unsigned calc_pw(input int unsigned a_w, input int unsigned w_w);
        return a_w + w_w;
    endfunction

    // Low lane: bits [pw-1:0] of the packed product, sign-extended.
    function automatic lane_prod_t split_lo(input logic signed [MAX_P_W-1:0] p,
                                            input int unsigned pw);
        logic signed [MAX_P_W-1:0] lo_x;
        lo_x = (p <<< (MAX_P_W - pw)) >>> (MAX_P_W - pw);
        return MAX_PW'(lo_x);
    endfunction

    // High lane: bits [2pw-1:pw] plus the borrow taken by a negative low lane.
    function automatic lane_prod_t split_hi(input logic signed [MAX_P_W-1:0] p,
                                            input int unsigned pw);
        logic signed [MAX_P_W-1:0] hi_x;
        logic signed [MAX_P_W-1:0] borrow;
        lane_prod_t                lo;
        lo        = split_lo(p, pw);
        borrow    = '0;
        borrow[0] = lo[MAX_PW-1];
        hi_x      = ((p >>> pw) <<< (MAX_P_W - pw)) >>> (MAX_P_W - pw);
        return MAX_PW'(hi_x + borrow);
    endfunction

    // Signed add clamped to a w-bit range; sat reports whether it clamped.
    function automatic logic signed [MAX_ACC_W-1:0] sat_add(
        input  logic signed [MAX_ACC_W-1:0] a,
        input  logic signed [MAX_ACC_W-1:0] b,
        input  int unsigned                 w,
        output logic                        sat
    );
        logic signed [MAX_SUM_W-1:0] s;
        logic signed [MAX_SUM_W-1:0] hi_lim;
        logic signed [MAX_SUM_W-1:0] lo_lim;
        s      = MAX_SUM_W'(a) + MAX_SUM_W'(b);
        hi_lim = (MAX_SUM_W'(1) <<< (w - 1)) - MAX_SUM_W'(1);
        lo_lim = -hi_lim - MAX_SUM_W'(1);
        sat    = 1'b0;
        if (s > hi_lim) begin
            sat = 1'b1;
            s   = hi_lim;
        end else if (s < lo_lim) begin
            sat = 1'b1;
            s   = lo_lim;
        end
        return MAX_ACC_W'(s);
    endfunction

endpackage

// File: rtl/packed_mul_core.sv
// Packs two unsigned activations, multiplies by one signed weight and splits
// the product into two signed lane products; one register stage with hold.
module packed_mul_core
    import dual_mac_pkg::*;
#(
    parameter  int unsigned A_W = 8,
    parameter  int unsigned W_W = 8,
    localparam int unsigned PW  = calc_pw(A_W, W_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [A_W-1:0]        act_a,
    input  logic [A_W-1:0]        act_b,
    input  logic signed [W_W-1:0] weight,
    output logic signed [PW-1:0]  hi,
    output logic signed [PW-1:0]  lo
);

    localparam int unsigned PK_W = A_W + PW;
    localparam int unsigned P_W  = 2 * PW + 1;

    logic [PK_W-1:0]       pk_c;
    logic signed [P_W-1:0] prod_c;
    logic signed [PW-1:0]  hi_d, hi_q, lo_d, lo_q;

    always_comb begin
        pk_c   = (PK_W'(act_a) << PW) + PK_W'(act_b);
        prod_c = P_W'($signed({1'b0, pk_c})) * P_W'(weight);
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (en) begin
            hi_d = PW'(split_hi(MAX_P_W'(prod_c), PW));
            lo_d = PW'(split_lo(MAX_P_W'(prod_c), PW));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/packed_dual_mac.sv
// Dual-lane MAC: input stage, shared packed multiplier, accumulators and result
// register under valid/ready. Define ACC_SAT_EN for saturating lane sums.
module packed_dual_mac
    import dual_mac_pkg::*;
#(
    parameter  int unsigned A_W   = 8,
    parameter  int unsigned W_W   = 8,
    parameter  int unsigned ACC_W = 32,
    localparam int unsigned PW    = calc_pw(A_W, W_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [A_W-1:0]          act_a,
    input  logic [A_W-1:0]          act_b,
    input  logic signed [W_W-1:0]   weight,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] acc_a,
    output logic signed [ACC_W-1:0] acc_b,
    output logic [1:0]              out_sat
);

    logic                    stall_c, accept_c;
    logic                    s1_valid_d, s1_valid_q, s1_first_d, s1_first_q, s1_last_d, s1_last_q;
    logic [A_W-1:0]          s1_act_a_d, s1_act_a_q, s1_act_b_d, s1_act_b_q;
    logic signed [W_W-1:0]   s1_weight_d, s1_weight_q;
    logic                    s2_valid_d, s2_valid_q, s2_first_d, s2_first_q, s2_last_d, s2_last_q;
    logic signed [PW-1:0]    s2_hi, s2_lo;
    logic signed [ACC_W-1:0] s3_acc_a_d, s3_acc_a_q, s3_acc_b_d, s3_acc_b_q;
    logic                    s3_sat_a_d, s3_sat_a_q, s3_sat_b_d, s3_sat_b_q;
    logic                    s3_done_d, s3_done_q;
    logic                    out_valid_d, out_valid_q;
    logic signed [ACC_W-1:0] out_acc_a_d, out_acc_a_q, out_acc_b_d, out_acc_b_q;
    logic [1:0]              out_sat_d, out_sat_q;
    logic signed [ACC_W-1:0] base_a_c, base_b_c;
`ifdef ACC_SAT_EN
    logic                    clamp_a_c, clamp_b_c;
`endif

    assign stall_c  = out_valid_q && !out_ready;
    assign in_ready = !stall_c;
    assign accept_c = in_valid && in_ready;

    packed_mul_core #(.A_W(A_W), .W_W(W_W)) u_core (
        .clk    (clk),
        .rst    (rst),
        .en     (!stall_c),
        .act_a  (s1_act_a_q),
        .act_b  (s1_act_b_q),
        .weight (s1_weight_q),
        .hi     (s2_hi),
        .lo     (s2_lo)
    );

    // Whole pipeline advances together and freezes on a stalled result.
    always_comb begin
        s1_valid_d  = s1_valid_q;  s1_first_d  = s1_first_q;  s1_last_d = s1_last_q;
        s1_act_a_d  = s1_act_a_q;  s1_act_b_d  = s1_act_b_q;  s1_weight_d = s1_weight_q;
        s2_valid_d  = s2_valid_q;  s2_first_d  = s2_first_q;  s2_last_d = s2_last_q;
        s3_acc_a_d  = s3_acc_a_q;  s3_acc_b_d  = s3_acc_b_q;
        s3_sat_a_d  = s3_sat_a_q;  s3_sat_b_d  = s3_sat_b_q;  s3_done_d = s3_done_q;
        out_valid_d = out_valid_q; out_acc_a_d = out_acc_a_q; out_acc_b_d = out_acc_b_q;
        out_sat_d   = out_sat_q;
        base_a_c    = s2_first_q ? '0 : s3_acc_a_q;
        base_b_c    = s2_first_q ? '0 : s3_acc_b_q;
`ifdef ACC_SAT_EN
        clamp_a_c   = 1'b0;
        clamp_b_c   = 1'b0;
`endif
        if (!stall_c) begin
            s1_valid_d = accept_c;
            if (accept_c) begin
                s1_first_d  = in_first;
                s1_last_d   = in_last;
                s1_act_a_d  = act_a;
                s1_act_b_d  = act_b;
                s1_weight_d = weight;
            end
            s2_valid_d = s1_valid_q;
            s2_first_d = s1_first_q;
            s2_last_d  = s1_last_q;
            s3_done_d  = s2_valid_q && s2_last_q;
            if (s2_valid_q) begin
`ifdef ACC_SAT_EN
                s3_acc_a_d = ACC_W'(sat_add(MAX_ACC_W'(base_a_c), MAX_ACC_W'(s2_hi), ACC_W, clamp_a_c));
                s3_acc_b_d = ACC_W'(sat_add(MAX_ACC_W'(base_b_c), MAX_ACC_W'(s2_lo), ACC_W, clamp_b_c));
                s3_sat_a_d = (s3_sat_a_q && !s2_first_q) || clamp_a_c;
                s3_sat_b_d = (s3_sat_b_q && !s2_first_q) || clamp_b_c;
`else
                s3_acc_a_d = base_a_c + ACC_W'(s2_hi);
                s3_acc_b_d = base_b_c + ACC_W'(s2_lo);
                s3_sat_a_d = 1'b0;
                s3_sat_b_d = 1'b0;
`endif
            end
            out_valid_d = s3_done_q;
            if (s3_done_q) begin
                out_acc_a_d = s3_acc_a_q;
                out_acc_b_d = s3_acc_b_q;
                out_sat_d   = {s3_sat_a_q, s3_sat_b_q};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0; s1_first_q <= 1'b0; s1_last_q  <= 1'b0;
            s1_act_a_q  <= '0;   s1_act_b_q <= '0;   s1_weight_q <= '0;
            s2_valid_q  <= 1'b0; s2_first_q <= 1'b0; s2_last_q  <= 1'b0;
            s3_acc_a_q  <= '0;   s3_acc_b_q <= '0;
            s3_sat_a_q  <= 1'b0; s3_sat_b_q <= 1'b0; s3_done_q  <= 1'b0;
            out_valid_q <= 1'b0; out_acc_a_q <= '0;  out_acc_b_q <= '0;
            out_sat_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;  s1_first_q  <= s1_first_d;  s1_last_q   <= s1_last_d;
            s1_act_a_q  <= s1_act_a_d;  s1_act_b_q  <= s1_act_b_d;  s1_weight_q <= s1_weight_d;
            s2_valid_q  <= s2_valid_d;  s2_first_q  <= s2_first_d;  s2_last_q   <= s2_last_d;
            s3_acc_a_q  <= s3_acc_a_d;  s3_acc_b_q  <= s3_acc_b_d;
            s3_sat_a_q  <= s3_sat_a_d;  s3_sat_b_q  <= s3_sat_b_d;  s3_done_q   <= s3_done_d;
            out_valid_q <= out_valid_d; out_acc_a_q <= out_acc_a_d; out_acc_b_q <= out_acc_b_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign acc_a     = out_acc_a_q;
    assign acc_b     = out_acc_b_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_packed_dual_mac.sv
// Scoreboard bench for packed_dual_mac: default instance plus an ACC_W=16 instance.
module tb_packed_dual_mac;

    localparam int unsigned A_W = 8;
    localparam int unsigned W_W = 8;

    typedef struct packed {
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic [1:0]         sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                  in_valid, in_ready, in_first, in_last, out_valid, out_ready;
    logic [A_W-1:0]        act_a, act_b;
    logic signed [W_W-1:0] weight;
    logic signed [31:0]    acc_a, acc_b;
    logic [1:0]            out_sat;

    logic                  d16_in_valid, d16_in_ready, d16_in_first, d16_in_last;
    logic                  d16_out_valid, d16_out_ready;
    logic [A_W-1:0]        d16_act_a, d16_act_b;
    logic signed [W_W-1:0] d16_weight;
    logic signed [15:0]    d16_acc_a, d16_acc_b;
    logic [1:0]            d16_out_sat;

    exp_t sb[$];
    exp_t sb16[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;

    packed_dual_mac #(.A_W(8), .W_W(8), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .act_a(act_a), .act_b(act_b),
        .weight(weight), .out_valid(out_valid), .out_ready(out_ready),
        .acc_a(acc_a), .acc_b(acc_b), .out_sat(out_sat)
    );

    packed_dual_mac #(.A_W(8), .W_W(8), .ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
        .in_first(d16_in_first), .in_last(d16_in_last), .act_a(d16_act_a), .act_b(d16_act_b),
        .weight(d16_weight), .out_valid(d16_out_valid), .out_ready(d16_out_ready),
        .acc_a(d16_acc_a), .acc_b(d16_acc_b), .out_sat(d16_out_sat)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int a, input int b, input logic [1:0] s);
        exp_t e;
        e.a = a;
        e.b = b;
        e.sat = s;
        return e;
    endfunction

    // Monitors: a result is consumed on the edge following this sample point.
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("acc_a", acc_a, e.a);
                check("acc_b", acc_b, e.b);
                check("out_sat", out_sat, e.sat);
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (!rst && d16_out_valid && d16_out_ready) begin
            if (sb16.size() == 0) begin
                check("unexpected_result16", 1, 0);
            end else begin
                exp_t e;
                e = sb16.pop_front();
                check("acc16_a", d16_acc_a, e.a);
                check("acc16_b", d16_acc_b, e.b);
                check("out_sat16", d16_out_sat, e.sat);
            end
        end
    end

    task automatic send(input int a, input int b, input int w, input bit f, input bit l);
        int n;
        bit ok;
        n = 0;
        @(negedge clk);
        act_a = A_W'(a); act_b = A_W'(b); weight = W_W'(w);
        in_first = f; in_last = l; in_valid = 1'b1;
        forever begin
            #1 ok = in_ready;
            @(posedge clk);
            if (ok) break;
            stall_cnt++;
            n++;
            if (n > 100) begin
                check("send_timeout", n, 0);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || sb16.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain", sb.size() + sb16.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        act_a = '0; act_b = '0; weight = '0; out_ready = 1'b1;
        d16_in_valid = 1'b0; d16_in_first = 1'b0; d16_in_last = 1'b0;
        d16_act_a = '0; d16_act_b = '0; d16_weight = '0; d16_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_acc_a", acc_a, 0);
        check("rst_acc_b", acc_b, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Single beat with 3-cycle latency
        send(200, 100, -3, 1, 1);
        sb.push_back(mk(-600, -300, 2'b00));
        idle();
        #1 check("lat_k1", out_valid, 0);
        @(negedge clk);
        @(negedge clk);
        #1 check("lat_k2", out_valid, 0);
        @(negedge clk);
        #1 check("lat_k3", out_valid, 1);
        wait_drain();

        // Borrow correction cases
        send(1, 0, -1, 1, 1);
        sb.push_back(mk(-1, 0, 2'b00));
        send(255, 255, -128, 1, 1);
        sb.push_back(mk(-32640, -32640, 2'b00));
        idle();
        wait_drain();

        // Two back-to-back four-beat frames, then a continuation beat without first
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) send(1, 2, 5, i == 0, i == 3);
        sb.push_back(mk(20, 40, 2'b00));
        for (int i = 0; i < 4; i++) send(3, 4, -2, i == 0, i == 3);
        sb.push_back(mk(-24, -32, 2'b00));
        check("b2b_stalls", stall_cnt, 0);
        send(1, 1, 1, 1, 1);
        sb.push_back(mk(1, 1, 2'b00));
        send(2, 2, 2, 0, 1);
        sb.push_back(mk(5, 5, 2'b00));
        idle();
        wait_drain();

        // Backpressure with a second frame in flight
        out_ready = 1'b0;
        send(5, 6, 7, 1, 1);
        sb.push_back(mk(35, 42, 2'b00));
        send(1, 1, 1, 1, 0);
        send(1, 1, 1, 0, 1);
        sb.push_back(mk(2, 2, 2'b00));
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_a", acc_a, 35);
            check("bp_hold_b", acc_b, 42);
        end
        out_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a frame with a held result
        out_ready = 1'b0;
        send(10, 20, 1, 1, 1);
        send(7, 7, 7, 1, 0);
        send(7, 7, 7, 0, 0);
        idle();
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_acc_a", acc_a, 10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_acc_a", acc_a, 0);
        check("mid_rst_acc_b", acc_b, 0);
        check("mid_rst_in_ready", in_ready, 1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(3, 4, 2, 1, 1);
        sb.push_back(mk(6, 8, 2'b00));
        idle();
        wait_drain();

        // 16-bit accumulator overflow
        check("d16_in_ready", d16_in_ready, 1);
        @(negedge clk);
        d16_act_a = 8'd255; d16_act_b = 8'd255; d16_weight = 8'sd127;
        d16_in_first = 1'b1; d16_in_last = 1'b0; d16_in_valid = 1'b1;
        @(negedge clk);
        d16_in_first = 1'b0; d16_in_last = 1'b1;
`ifdef ACC_SAT_EN
        sb16.push_back(mk(32767, 32767, 2'b11));
`else
        sb16.push_back(mk(-766, -766, 2'b00));
`endif
        @(negedge clk);
        d16_in_valid = 1'b0; d16_in_last = 1'b0;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
